// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer (start, data, parity, stop).
// Optional UART_RX_SYNC_EN adds a 2-flop synchronizer on RX_IN.
module uart_rx_ctrl #(
  parameter int PRESCALE_BITS = 5,
  parameter int DATA_BITS     = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic                     PAR_EN,
  input  logic [PRESCALE_BITS-1:0] Prescale,
  input  logic                     strt_glitch,
  input  logic                     par_err,
  input  logic                     stp_err,
  output logic [PRESCALE_BITS-1:0] edge_cnt,
  output logic [3:0]               bit_cnt,
  output logic                     dat_samp_en,
  output logic                     deser_en,
  output logic                     strt_chk_en,
  output logic                     par_chk_en,
  output logic                     stp_chk_en,
  output logic                     data_valid,
  output logic                     busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [2:0]               state;
  logic                     par_en_q;
  logic                     par_flag;
  logic                     rx;
  logic                     bit_end;
  logic [PRESCALE_BITS-1:0] last_edge;
  logic [PRESCALE_BITS-1:0] edge_inc;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], RX_IN};
    end
  end

  assign rx = rx_sync[1];
`else
  assign rx = RX_IN;
`endif

  assign last_edge = Prescale - PRESCALE_BITS'(1);
  assign bit_end   = (edge_cnt == last_edge);
  assign edge_inc  = bit_end ? '0 : edge_cnt + PRESCALE_BITS'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      par_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx) begin
            state    <= START;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            par_en_q <= PAR_EN;
          end
        end
        START: begin
          edge_cnt <= edge_inc;
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          // A glitchy start is judged on the first data cycle
          if (bit_cnt == '0 && edge_cnt == '0 && strt_glitch) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            edge_cnt <= edge_inc;
            if (bit_end) begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end
        PARITY: begin
          edge_cnt <= edge_inc;
          if (bit_end) begin
            state <= STOP;
          end
        end
        STOP: begin
          edge_cnt <= edge_inc;
          if (edge_cnt == '0) begin
            par_flag <= par_en_q & par_err;
          end
          if (bit_end) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign dat_samp_en = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
  assign deser_en    = (state == DATA) && bit_end;
  assign strt_chk_en = (state == START);
  assign par_chk_en  = (state == PARITY);
  assign stp_chk_en  = (state == STOP);
  assign data_valid  = (state == CHECK) && !stp_err && !par_flag;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame-timing checks for uart_rx_ctrl.
// Expected cycle positions come from the frame timing formulas.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [4:0] Prescale = 5'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(
    .PRESCALE_BITS(5),
    .DATA_BITS(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .Prescale(Prescale),
    .strt_glitch(strt_glitch),
    .par_err(par_err),
    .stp_err(stp_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en),
    .deser_en(deser_en),
    .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
    .data_valid(data_valid),
    .busy(busy)
  );

  function automatic logic [15:0] outs();
    return {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
            par_chk_en, stp_chk_en, data_valid, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // pre: already at T0; chain: drive the next start bit from CHECK on
  task automatic frame(input string tag, input int p, input logic [7:0] d,
                       input bit par, input bit perr, input bit serr,
                       input bit tog, input bit pre, input bit chain);
    int tc, lim, dv_at, dv_n, ds_n, ds_bad, pc_first, pc_n, b_end;
    bit ok;
    tc = p * (10 + int'(par));
    lim = chain ? tc + 1 : tc + p + 2;
    dv_at = -1; dv_n = 0; ds_n = 0; ds_bad = 0;
    pc_first = -1; pc_n = 0; b_end = -1;
    ok = !(par && perr) && !serr;
    Prescale = 5'(p);
    PAR_EN = par;
    par_err = perr;
    stp_err = serr;
    if (!pre) begin
      RX_IN = 1'b0;
      tick();
    end
    chk({tag, "_t0"}, {busy, strt_chk_en, dat_samp_en}, 3'b111);
    for (int t = 0; t <= lim; t++) begin
      if (tog) PAR_EN = t[0];
      if (t < p) RX_IN = 1'b0;
      else if (t < 9 * p) RX_IN = d[(t - p) / p];
      else if (par && t < 10 * p) RX_IN = ^d;
      else RX_IN = 1'b1;
      if (chain && t >= tc) RX_IN = 1'b0;
      #1;
      if (deser_en) begin
        ds_n++;
        if ((t + 1) % p != 0 || t < 2 * p - 1 || t > 9 * p - 1) ds_bad++;
      end
      if (data_valid) begin
        dv_n++;
        if (dv_at < 0) dv_at = t;
      end
      if (par_chk_en) begin
        pc_n++;
        if (pc_first < 0) pc_first = t;
      end
      if (!busy && b_end < 0) b_end = t;
      tick();
    end
    chk({tag, "_deser_n"}, ds_n, 8);
    chk({tag, "_deser_pos"}, ds_bad, 0);
    chk({tag, "_dv_n"}, dv_n, ok ? 1 : 0);
    chk({tag, "_dv_at"}, dv_at, ok ? tc : -1);
    chk({tag, "_busy_end"}, b_end, tc + 1);
    chk({tag, "_par_n"}, pc_n, par ? p : 0);
    if (par) chk({tag, "_par_first"}, pc_first, 9 * p);
  endtask

  initial begin
    int ds_n, dv_n;
    #12;
    chk("reset_outs", outs(), 16'h0);
    RST = 1'b1;
    tick();
    tick();
    chk("idle_outs", outs(), 16'h0);

    frame("f55", 8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    Prescale = 5'd8;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    tick();
    RX_IN = 1'b1;
    repeat (8) tick();
    strt_glitch = 1'b1;
    tick();
    strt_glitch = 1'b0;
    #1;
    chk("glitch_idle", {busy, edge_cnt, bit_cnt}, 10'h0);
    ds_n = 0;
    dv_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (deser_en) ds_n++;
      if (data_valid) dv_n++;
      tick();
    end
    chk("glitch_deser", ds_n, 0);
    chk("glitch_dv", dv_n, 0);

    frame("par_ok", 8, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame("par_bad", 8, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame("stp_bad", 16, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stp_err = 1'b0;

    Prescale = 5'd16;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    tick();
    RX_IN = 1'b1;
    repeat (69) tick();
    chk("rst_bit3", bit_cnt, 4'd3);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_outs", outs(), 16'h0);
    tick();
    tick();
    chk("rst_hold", outs(), 16'h0);
    #2;
    RST = 1'b1;
    tick();
    chk("rst_release", outs(), 16'h0);
    frame("post_rst", 16, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    frame("b2b_a", 8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame("b2b_b", 8, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
